// File: rtl/seq_checker_if.sv
// seq_checker_if: counter sample inputs and checker status outputs.
//   in_a/in_b/in_c : counter Q_A/Q_B/Q_C
//   idx            : cycle position of last sampled code, 7 = invalid
//   locked         : checker is locked onto a legal run
//   err            : sticky fault flag
//   step_cnt       : legal transitions counted while locked (CNT_W bits)
//   cycle_done     : one-cycle pulse on a locked 5->0 transition
//   err_cnt        : saturating fault count
// master drives the counter side, slave is the checker.
interface seq_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_a;
  logic             in_b;
  logic             in_c;
  logic [2:0]       idx;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] step_cnt;
  logic             cycle_done;
  logic [3:0]       err_cnt;

  modport master (
    output in_a, in_b, in_c,
    input  idx, locked, err, step_cnt, cycle_done, err_cnt
  );

  modport slave (
    input  in_a, in_b, in_c,
    output idx, locked, err, step_cnt, cycle_done, err_cnt
  );
endinterface

// File: rtl/seq_checker.sv
// seq_checker: monitors a 3-bit six-state sequence counter, locks onto a
// legal run, counts steps and completed cycles, and flags illegal codes or
// transitions.
// Ports:
//   clk : rising-edge clock shared with the counter
//   rst : asynchronous active-low reset
//   bus : seq_checker_if.slave (counter sample in, status out)
// Build option: define SEQ_CHECKER_ERRCNT_EN to implement the 4-bit
// saturating fault counter on err_cnt; otherwise err_cnt reads 0.
module seq_checker #(
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_checker_if.slave bus
);

  localparam int unsigned RUN_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Code to cycle position; 110 and 111 map to 7.
  function automatic logic [2:0] code_idx(input logic [2:0] code);
    logic [2:0] r;
    case (code)
      3'b000:  r = 3'd0;
      3'b100:  r = 3'd1;
      3'b001:  r = 3'd2;
      3'b010:  r = 3'd3;
      3'b101:  r = 3'd4;
      3'b011:  r = 3'd5;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       cur_q, prev_q;
  logic             cv_q, pv_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       idx_q;
  logic             locked_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             cyc_q, cyc_d;
  logic             fault_entry;

  logic [2:0] code_c;
  logic [2:0] prev_idx, cur_idx;
  logic       legal, hold_zero;

  assign code_c    = {bus.in_a, bus.in_b, bus.in_c};
  assign prev_idx  = code_idx(prev_q);
  assign cur_idx   = code_idx(cur_q);
  assign legal     = (prev_idx != 3'd7) &&
                     (cur_idx == ((prev_idx == 3'd5) ? 3'd0 : prev_idx + 3'd1));
  assign hold_zero = (prev_q == 3'b000) && (cur_q == 3'b000);

  // Judge the prev_q -> cur_q transition once prev_q holds a real sample.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    step_d  = step_q;
    cyc_d   = 1'b0;
    if (pv_q) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            if (run_q == RUN_W'(LOCK_LEN - 1)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else if (hold_zero) begin
            run_d = '0;
          end else begin
            state_d = FAULT;
          end
        end
        LOCKED: begin
          if (legal) begin
            step_d = step_q + 1'b1;
            cyc_d  = (prev_idx == 3'd5);
          end else if (hold_zero) begin
            state_d = HUNT;
            run_d   = '0;
          end else begin
            state_d = FAULT;
          end
        end
        FAULT: begin
          if (cur_q == 3'b000) begin
            state_d = HUNT;
            run_d   = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    fault_entry = (state_d == FAULT) && (state_q != FAULT);
    err_d       = err_q | fault_entry;
  end

  // Sample pipeline, FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q    <= 3'b000;
      prev_q   <= 3'b000;
      cv_q     <= 1'b0;
      pv_q     <= 1'b0;
      idx_q    <= 3'd0;
      state_q  <= HUNT;
      run_q    <= '0;
      step_q   <= '0;
      cyc_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cur_q    <= code_c;
      prev_q   <= cur_q;
      cv_q     <= 1'b1;
      pv_q     <= cv_q;
      idx_q    <= code_idx(code_c);
      state_q  <= state_d;
      run_q    <= run_d;
      step_q   <= step_d;
      cyc_q    <= cyc_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
    end
  end

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic [3:0] err_cnt_q;

  // Counts FAULT entries, saturating at 15.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 4'd0;
    end else if (fault_entry && (err_cnt_q != 4'hF)) begin
      err_cnt_q <= err_cnt_q + 4'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 4'd0;
`endif

  assign bus.idx        = idx_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.step_cnt   = step_q;
  assign bus.cycle_done = cyc_q;

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: drives two checkers (CNT_W=8 and CNT_W=4) with the same
// directed code stream and compares every output against a sample-history
// model each cycle, plus hand-computed literal expectations.
module tb_seq_checker;

  localparam int LOCK_LEN = 3;
`ifdef SEQ_CHECKER_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  // Legal ring in cycle order, entry i at bits [3i+2:3i].
  localparam logic [17:0] RING = {3'b011, 3'b101, 3'b010, 3'b001, 3'b100, 3'b000};

  localparam logic [1:0] M_HUNT  = 2'd0;
  localparam logic [1:0] M_LOCK  = 2'd1;
  localparam logic [1:0] M_FAULT = 2'd2;

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  run;
    logic [1:0]  seen;
    logic [2:0]  prev;
    logic [2:0]  cur;
    logic [31:0] steps;
    logic [3:0]  faults;
    logic        sticky;
    logic        pulse;
  } mstate_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_checker_if #(.CNT_W(8)) if8 ();
  seq_checker_if #(.CNT_W(4)) if4 ();

  seq_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(8)) dut8 (.clk(clk), .rst(rst_n), .bus(if8));
  seq_checker #(.LOCK_LEN(LOCK_LEN), .CNT_W(4)) dut4 (.clk(clk), .rst(rst_n), .bus(if4));

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  mstate_t m   = '0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) begin
      if (RING[i*3 +: 3] == c) return i;
    end
    return 7;
  endfunction

  function automatic mstate_t enter_fault(input mstate_t s);
    mstate_t n;
    n        = s;
    n.mode   = M_FAULT;
    n.sticky = 1'b1;
    if (ERRCNT_EN && (s.faults != 4'd15)) n.faults = s.faults + 4'd1;
    return n;
  endfunction

  // Next model state from the two most recent samples and the new code.
  function automatic mstate_t model_next(input mstate_t s, input logic [2:0] code);
    mstate_t n;
    int      pp, pc;
    bit      legal, hold;
    n       = s;
    n.pulse = 1'b0;
    if (s.seen == 2'd2) begin
      pp    = pos_of(s.prev);
      pc    = pos_of(s.cur);
      legal = (pp != 7) && (pc == (pp + 1) % 6);
      hold  = (s.prev == 3'b000) && (s.cur == 3'b000);
      if (s.mode == M_HUNT) begin
        if (legal) begin
          if (int'(s.run) + 1 >= LOCK_LEN) begin
            n.mode = M_LOCK;
            n.run  = 4'd0;
          end else begin
            n.run = s.run + 4'd1;
          end
        end else if (hold) begin
          n.run = 4'd0;
        end else begin
          n = enter_fault(n);
        end
      end else if (s.mode == M_LOCK) begin
        if (legal) begin
          n.steps = s.steps + 32'd1;
          n.pulse = (pp == 5);
        end else if (hold) begin
          n.mode = M_HUNT;
          n.run  = 4'd0;
        end else begin
          n = enter_fault(n);
        end
      end else if (s.cur == 3'b000) begin
        n.mode = M_HUNT;
        n.run  = 4'd0;
      end
    end
    n.prev = s.cur;
    n.cur  = code;
    if (s.seen != 2'd2) n.seen = s.seen + 2'd1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, {if8.in_a, if8.in_b, if8.in_c});
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    cmp("idx8",    int'(if8.idx),        pos_of(m.cur));
    cmp("idx4",    int'(if4.idx),        pos_of(m.cur));
    cmp("locked8", int'(if8.locked),     int'(m.mode == M_LOCK));
    cmp("locked4", int'(if4.locked),     int'(m.mode == M_LOCK));
    cmp("err8",    int'(if8.err),        int'(m.sticky));
    cmp("err4",    int'(if4.err),        int'(m.sticky));
    cmp("step8",   int'(if8.step_cnt),   int'(m.steps[7:0]));
    cmp("step4",   int'(if4.step_cnt),   int'(m.steps[3:0]));
    cmp("cyc8",    int'(if8.cycle_done), int'(m.pulse));
    cmp("cyc4",    int'(if4.cycle_done), int'(m.pulse));
    cmp("ecnt8",   int'(if8.err_cnt),    int'(m.faults));
    cmp("ecnt4",   int'(if4.err_cnt),    int'(m.faults));
  end

  task automatic drive(input logic [2:0] code);
    {if8.in_a, if8.in_b, if8.in_c} = code;
    {if4.in_a, if4.in_b, if4.in_c} = code;
  endtask

  // Present a code for the next rising edge.
  task automatic tick(input logic [2:0] code);
    @(negedge clk);
    drive(code);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_idx"},    int'(if8.idx) + int'(if4.idx), 0);
    cmp({tag, "_locked"}, int'(if8.locked) + int'(if4.locked), 0);
    cmp({tag, "_err"},    int'(if8.err) + int'(if4.err), 0);
    cmp({tag, "_step"},   int'(if8.step_cnt) + int'(if4.step_cnt), 0);
    cmp({tag, "_cyc"},    int'(if8.cycle_done) + int'(if4.cycle_done), 0);
    cmp({tag, "_ecnt"},   int'(if8.err_cnt) + int'(if4.err_cnt), 0);
  endtask

  // Assert reset mid-cycle, check outputs clear, release with a first code.
  task automatic pulse_reset(input logic [2:0] first);
    #1 rst_n = 1'b0;
    #1 chk_zero("in_reset");
    repeat (2) @(negedge clk);
    drive(first);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(3'b000);
    repeat (3) @(negedge clk);
    chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;                    // e1 samples 000

    // Clean start.
    tick(3'b100); tick(3'b001); tick(3'b010); tick(3'b101);
    cmp("pre_lock", int'(if8.locked), 0);
    tick(3'b011);
    cmp("lock_lat", int'(if8.locked), 1);
    tick(3'b000); tick(3'b100); tick(3'b001);
    cmp("clean_step", int'(if8.step_cnt), 3);
    cmp("clean_cyc",  int'(if8.cycle_done), 1);
    cmp("clean_err",  int'(if8.err), 0);

    // Upstream held at zero after a legal 5->0 step.
    tick(3'b010); tick(3'b101); tick(3'b011);
    tick(3'b000); tick(3'b000); tick(3'b000); tick(3'b000);
    tick(3'b100);
    cmp("hold_locked", int'(if8.locked), 0);
    cmp("hold_err",    int'(if8.err), 0);
    cmp("hold_step",   int'(if8.step_cnt), 9);
    tick(3'b001); tick(3'b010); tick(3'b101);
    cmp("relock_pre", int'(if8.locked), 0);
    tick(3'b011);
    cmp("relock", int'(if8.locked), 1);

    // Invalid code while locked, then recover through 000.
    tick(3'b110); tick(3'b000); tick(3'b000);
    cmp("inv_err",    int'(if8.err), 1);
    cmp("inv_locked", int'(if8.locked), 0);
    cmp("inv_ecnt",   int'(if8.err_cnt), ERRCNT_EN ? 1 : 0);
    tick(3'b000);
    cmp("inv_sticky", int'(if8.err), 1);

    // Skipped state while locked, illegal codes persist for 5 cycles.
    tick(3'b100); tick(3'b001); tick(3'b010); tick(3'b101);
    tick(3'b011); tick(3'b000); tick(3'b100); tick(3'b010);
    for (int i = 0; i < 5; i++) tick(3'b010);
    tick(3'b000); tick(3'b000);
    cmp("skip_ecnt",   int'(if8.err_cnt), ERRCNT_EN ? 2 : 0);
    cmp("skip_locked", int'(if8.locked), 0);

    // Relock, then reset mid-run; first verdict lands on the third edge.
    tick(3'b100); tick(3'b001); tick(3'b010); tick(3'b101); tick(3'b011);
    cmp("pre_rst_locked", int'(if8.locked), 1);
    cmp("pre_rst_ecnt",   int'(if8.err_cnt), ERRCNT_EN ? 2 : 0);
    pulse_reset(3'b110);
    tick(3'b110); tick(3'b000);
    cmp("rst_edge2_err", int'(if8.err), 0);
    tick(3'b000);
    cmp("rst_edge3_err", int'(if8.err), 1);

    // Lock on a 5->0 transition, then 17 legal steps to wrap the 4-bit count.
    @(negedge clk);
    pulse_reset(3'b010);
    tick(3'b101); tick(3'b011); tick(3'b000);
    pulses = 0;
    for (int i = 1; i <= 17; i++) begin
      tick(RING[(i % 6)*3 +: 3]);
      pulses += int'(if4.cycle_done);
      if (i == 2) begin
        cmp("lock_on_wrap_locked", int'(if8.locked), 1);
        cmp("lock_on_wrap_step",   int'(if8.step_cnt), 0);
        cmp("lock_on_wrap_cyc",    int'(if8.cycle_done), 0);
      end
    end
    tick(3'b110);
    pulses += int'(if4.cycle_done);
    tick(3'b110);
    pulses += int'(if4.cycle_done);
    cmp("wrap_step4",  int'(if4.step_cnt), 1);
    cmp("wrap_step8",  int'(if8.step_cnt), 17);
    cmp("wrap_pulses", pulses, 2);

    // Invalid code arriving when the run would have completed the lock.
    @(negedge clk);
    pulse_reset(3'b000);
    tick(3'b100); tick(3'b001); tick(3'b110); tick(3'b110); tick(3'b110);
    cmp("race_locked", int'(if8.locked), 0);
    cmp("race_err",    int'(if8.err), 1);

    repeat (3) tick(3'b000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
